// File: rtl/pwm_compare.sv
// PWM compare/output stage fed by an up-counter. Duty updates are double-buffered:
// a handshake loads a shadow register, which becomes active only at the period wrap.
module pwm_compare #(
  parameter int            BITS      = 4,
  parameter bit            POLARITY  = 1'b0,
  parameter logic [BITS:0] INIT_DUTY = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [BITS-1:0] cnt,
  input  logic [BITS:0] duty_in,
  input  logic          duty_valid,
  output logic          duty_ready,
  output logic          pwm_out,
  output logic          period_done,
  output logic          update_ack
);

  localparam logic [BITS:0]   FULL_DUTY = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS-1:0] CNT_MAX   = {BITS{1'b1}};

  typedef enum logic {IDLE, PENDING} state_e;

  state_e        state_q, state_d;
  logic [BITS:0] shadow_q, shadow_d;
  logic [BITS:0] duty_act_q, duty_act_d;
  logic          pwm_q, pwm_d;
  logic          period_done_q, period_done_d;
  logic          update_ack_q, update_ack_d;

  logic          wrap;
  logic [BITS:0] duty_sat;

  assign wrap     = en && (cnt == CNT_MAX);
  assign duty_sat = (duty_in > FULL_DUTY) ? FULL_DUTY : duty_in;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d       = state_q;
    shadow_d      = shadow_q;
    duty_act_d    = duty_act_q;
    pwm_d         = pwm_q;
    period_done_d = wrap;
    update_ack_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (duty_valid) begin
          shadow_d = duty_sat;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        // A value accepted on a wrap cycle is still IDLE here, so it waits a full period.
        if (wrap) begin
          duty_act_d   = shadow_q;
          update_ack_d = 1'b1;
          state_d      = IDLE;
        end
      end
    endcase

    // Compare uses the current active duty; a swap on this edge is seen from cnt==0 on.
    if (en) begin
      pwm_d = POLARITY ^ ({1'b0, cnt} < duty_act_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      duty_act_q    <= INIT_DUTY;
      pwm_q         <= POLARITY;
      period_done_q <= 1'b0;
      update_ack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      duty_act_q    <= duty_act_d;
      pwm_q         <= pwm_d;
      period_done_q <= period_done_d;
      update_ack_q  <= update_ack_d;
    end
  end

  assign duty_ready  = (state_q == IDLE);
  assign pwm_out     = pwm_q;
  assign period_done = period_done_q;
  assign update_ack  = update_ack_q;

endmodule
